mul_share_arbiter: RTL
======================

# mul_share_arbiter

Round-robin arbiter and sequencer that shares one shift-add multiplier instance among NREQ requesters. It accepts one request at a time and drives the multiplier's start/operand interface. It waits for the multiplier's ready, then returns the full product to the granted requester with a one-cycle done pulse. A watchdog aborts a hung multiply with an error flag.

## Interface
Parameters:
- n, 32, operand width; product is 2n bits
- NREQ, 4, number of requesters (≥2)
- TIMEOUT, 2*n+8, max WAIT cycles before abort

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  request level, bit i = requester i
- req_a  in  NREQ*n  multiplier operands, slice i = bits [i*n +: n]
- req_b  in  NREQ*n  multiplicand operands, same packing
- gnt  out  NREQ  one-hot, one-cycle pulse: request accepted
- done  out  NREQ  one-hot, one-cycle pulse: result valid for that requester
- result  out  2n  product of last completed job, held until next DELIVER
- err  out  1  valid with done; 1 = timeout abort
- busy  out  1  high in every state except IDLE
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_multiplier  out  n  registered operand to multiplier
- mul_multiplicand  out  n  registered operand to multiplier
- mul_ready  in  1  multiplier completion flag
- mul_product  in  2n  multiplier result, valid while mul_ready=1

## Operation
- FSM states: IDLE, ISSUE, WAIT, DELIVER. All outputs are registered.
- IDLE: if any req bit is set, pick the winner by round-robin. Search starts at ptr+1 mod NREQ and takes the first set bit. Latch the winner index into owner. Latch its req_a/req_b into mul_multiplier/mul_multiplicand. Go to ISSUE. mul_ready is ignored in IDLE.
- ISSUE (1 cycle): gnt[owner]=1, mul_start=1. Clear the timeout counter. Go to WAIT.
- WAIT: the counter increments each cycle. mul_ready is ignored in the first WAIT cycle, which masks a stale ready from the previous job.
  - From the second WAIT cycle on, if mul_ready=1: result<=mul_product, err<=0, go to DELIVER.
  - Else if the counter reaches TIMEOUT: result<=0, err<=1, go to DELIVER.
  - If mul_ready and timeout occur in the same cycle, mul_ready wins (err=0).
- DELIVER (1 cycle): done[owner]=1. ptr<=owner. Go to IDLE.
- mul_multiplier/mul_multiplicand hold stable from ISSUE through DELIVER.
- Requester contract:
  - Hold req and operands stable until gnt.
  - req may stay high after gnt; a new request is re-arbitrated only after DELIVER.
  - A requester that drops req before gnt is simply not granted. No pending memory is kept.
- Arithmetic: unsigned. The product passes through unmodified at 2n bits; the block does no truncation.

## Timing
- Reset values: state=IDLE, gnt=0, done=0, result=0, err=0, busy=0, mul_start=0, mul_multiplier=0, mul_multiplicand=0, ptr=NREQ-1 (requester 0 has first priority), counter=0.
- req sampled high at edge E0 in IDLE. Then:
  - cycle after E0: ISSUE (gnt, mul_start high)
  - next cycle: first WAIT cycle
- mul_ready sampled high at edge Ek in WAIT → DELIVER in the following cycle.
- Total latency from req sampled to done = multiplier latency + 3 cycles.
- Back-to-back throughput: at least one IDLE cycle between DELIVER and the next ISSUE.
- Reset asserted mid-operation (any state):
  - Next cycle is IDLE with all reset values.
  - No done is issued for the aborted job.
  - A late mul_ready from the aborted job is ignored.
- After a timeout, a late mul_ready is ignored in IDLE and masked by the first WAIT cycle of the next job.

## Test plan
- Single request: NREQ=4, n=8, req=0001, a=13, b=11, multiplier model ready 16 cycles after start → gnt[0] one cycle after req, one mul_start pulse, done[0] with result=143, err=0, busy low after DELIVER.
- Round-robin fairness: req=1111 held, all operands distinct → grant order 0,1,2,3,0. Each result matches its own a*b. Exactly one gnt and one done per job, never two bits set.
- Boundary operands: a=255, b=255 (n=8) → result=65025. a=0, b=200 → result=0.
- Timeout: multiplier model never raises ready → done after TIMEOUT WAIT cycles with err=1, result=0. The next request then completes normally with err=0.
- Reset mid-WAIT: assert rst during job 2 of a stream → no done for job 2. All outputs return to reset values the next cycle, ptr=3. Then req=0110 → first grant goes to requester 1.
- Stale ready: model holds mul_ready=1 into the cycle after mul_start → that stale ready is ignored. result is captured only from the real completion.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// -----------------------------------------------------------------------------
// mul_share_arbiter
//
// Shares one multi-cycle multiplier among NREQ requesters. Requests are
// accepted one at a time with round-robin priority. The block issues a
// one-cycle start pulse with registered operands. It then waits for the
// multiplier's ready flag and returns the full 2n-bit product to the owner
// together with a one-cycle done pulse. A watchdog aborts a multiply that
// never completes and reports it through err.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req               request level per requester
//   req_a, req_b      packed operands, slice i = [i*n +: n]
//   gnt               one-hot pulse: request of that requester accepted
//   done              one-hot pulse: result/err valid for that requester
//   result            product of the last completed job (0 on abort)
//   err               1 = last job aborted by the watchdog
//   busy              high whenever the sequencer is not idle
//   mul_start         one-cycle start pulse to the multiplier
//   mul_multiplier    registered operand, stable from issue to delivery
//   mul_multiplicand  registered operand, stable from issue to delivery
//   mul_ready         multiplier completion flag
//   mul_product       multiplier result, valid while mul_ready is high
// -----------------------------------------------------------------------------
module mul_share_arbiter #(
  parameter int n       = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 2*n+8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*n-1:0] req_a,
  input  logic [NREQ*n-1:0] req_b,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [2*n-1:0]    result,
  output logic              err,
  output logic              busy,
  output logic              mul_start,
  output logic [n-1:0]      mul_multiplier,
  output logic [n-1:0]      mul_multiplicand,
  input  logic              mul_ready,
  input  logic [2*n-1:0]    mul_product
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [NREQ-1:0]  ONE_HOT0 = NREQ'(1);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NREQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DELIVER
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [NREQ-1:0]    done_q, done_d;
  logic [2*n-1:0]     result_q, result_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               start_q, start_d;
  logic [n-1:0]       mplier_q, mplier_d;
  logic [n-1:0]       mcand_q, mcand_d;

  // ---------------------------------------------------------------------------
  // Operand unpacking
  // ---------------------------------------------------------------------------
  logic [n-1:0] a_slice [NREQ];
  logic [n-1:0] b_slice [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign a_slice[gi] = req_a[gi*n +: n];
    assign b_slice[gi] = req_b[gi*n +: n];
  end

  // ---------------------------------------------------------------------------
  // Round-robin search
  // Candidate k (k = 0..NREQ-1) is requester (ptr + k + 1) mod NREQ. The
  // modulo is folded into a compare/subtract so no divider is built, and the
  // last candidate is always ptr itself (the previous owner is served last).
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] cand_idx [NREQ];
  logic [NREQ-1:0]  cand_hit;
  logic             win_valid;
  logic [IDX_W-1:0] win_idx;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    localparam int OFS = gi + 1;
    if (OFS == NREQ) begin : g_self
      assign cand_idx[gi] = ptr_q;
    end else begin : g_wrap
      assign cand_idx[gi] = (ptr_q >= IDX_W'(NREQ - OFS))
                          ? (ptr_q - IDX_W'(NREQ - OFS))
                          : (ptr_q + IDX_W'(OFS));
    end
    assign cand_hit[gi] = req[cand_idx[gi]];
  end

  // Walk from the lowest-priority candidate up so the nearest hit wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        win_valid = 1'b1;
        win_idx   = cand_idx[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    gnt_d    = '0;
    done_d   = '0;
    start_d  = 1'b0;
    result_d = result_q;
    err_d    = err_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;

    unique case (state_q)
      ST_IDLE: begin
        // mul_ready is deliberately not looked at here: a late ready from
        // an aborted job must not leak into anything.
        if (win_valid) begin
          owner_d  = win_idx;
          mplier_d = a_slice[win_idx];
          mcand_d  = b_slice[win_idx];
          gnt_d    = ONE_HOT0 << win_idx;
          start_d  = 1'b1;
          state_d  = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // cnt_q == 0 marks the first WAIT cycle; a ready seen there still
        // belongs to the previous job and is ignored. Ready is tested before
        // the watchdog so a completion on the last allowed cycle wins.
        if ((cnt_q != '0) && mul_ready) begin
          result_d = mul_product;
          err_d    = 1'b0;
          done_d   = ONE_HOT0 << owner_q;
          state_d  = ST_DELIVER;
        end else if (cnt_q == CNT_LAST) begin
          result_d = '0;
          err_d    = 1'b1;
          done_d   = ONE_HOT0 << owner_q;
          state_d  = ST_DELIVER;
        end
      end

      ST_DELIVER: begin
        ptr_d   = owner_q;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // busy is registered, so it follows the state being entered.
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      ptr_q    <= PTR_RST;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      mplier_q <= '0;
      mcand_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
    end
  end

  assign gnt              = gnt_q;
  assign done             = done_q;
  assign result           = result_q;
  assign err              = err_q;
  assign busy             = busy_q;
  assign mul_start        = start_q;
  assign mul_multiplier   = mplier_q;
  assign mul_multiplicand = mcand_q;

endmodule
